dmem_responder: RTL

- Memory-side responder for the MEM-stage data-memory request interface of the 5-stage pipelined CPU.
- Accepts one read or write request at a time, presented as level signals plus address and write data.
- Services the request from an internal word array after a configurable latency.
- Drives a stall (busy) back to the pipeline, then returns completion, read data and error status.

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the MEM stage and the responder.
// master: pipeline side (drives requests, sees stall/completion).
// slave : responder side (sees requests, drives stall/completion/read data/error).
interface dmem_responder_if;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;
  logic        err_o;

  modport master (
    output MemRead_i, MemWrite_i, addr_i, data_i,
    input  busy_o, done_o, data_o, err_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, data_i,
    output busy_o, done_o, data_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage data-memory interface.
// Accepts one read or write at a time, executes it against an internal word
// array LATENCY cycles after acceptance, stalls the pipeline meanwhile and
// returns a one-cycle completion with read data and error status.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   bus    - request/response bundle (slave side): MemRead_i, MemWrite_i,
//            addr_i, data_i in; busy_o (combinational stall), done_o,
//            data_o (registered read data), err_o (valid with done_o) out
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned LATENCY     = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dmem_responder_if.slave   bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_q, wr_q;
  logic [WORD_W-1:0]   addr_q, wdata_q;
  logic [WORD_W-1:0]   rdata_q;
  logic                err_q;

  logic                req_c;
  logic                busy_c;
  logic                latch_c;
  logic                exec_c;

  logic                op_rd_c, op_wr_c;
  logic [WORD_W-1:0]   op_addr_c, op_wdata_c;
  logic [IDX_W-1:0]    op_idx_c;
  logic                op_err_c;

  logic [WORD_W-1:0]   mem [DEPTH_WORDS];

  // Next-state, counter and stall logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_c  = 1'b0;
    latch_c = 1'b0;
    exec_c  = 1'b0;
    req_c   = bus.MemRead_i | bus.MemWrite_i;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          busy_c  = 1'b1;
          latch_c = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            // Single-cycle latency: the access happens on the accepting edge
            state_d = RESP;
            exec_c  = 1'b1;
          end
        end
      end
      WAIT: begin
        busy_c = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          exec_c  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operands for the access: live inputs on the accepting edge, latched after
  always_comb begin
    if (state_q == IDLE) begin
      op_rd_c    = bus.MemRead_i;
      op_wr_c    = bus.MemWrite_i;
      op_addr_c  = bus.addr_i;
      op_wdata_c = bus.data_i;
    end else begin
      op_rd_c    = rd_q;
      op_wr_c    = wr_q;
      op_addr_c  = addr_q;
      op_wdata_c = wdata_q;
    end
    op_idx_c = op_addr_c[IDX_W+1:2];
    op_err_c = (op_addr_c[1:0] != 2'b00)
             | (op_addr_c[31:2] >= 30'(DEPTH_WORDS))
             | (op_rd_c & op_wr_c);
  end

  // State, counter, request latch and response registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_c) begin
        rd_q    <= bus.MemRead_i;
        wr_q    <= bus.MemWrite_i;
        addr_q  <= bus.addr_i;
        wdata_q <= bus.data_i;
      end
      // err_q is only ever set on the access edge, so it is high only in RESP
      err_q <= exec_c & op_err_c;
      if (exec_c) begin
        if (op_err_c) begin
          rdata_q <= '0;
        end else if (op_rd_c) begin
          rdata_q <= mem[op_idx_c];
        end
      end
    end
  end

  // Word array; not reset. Gated by rst_i so an access never commits in reset.
  always_ff @(posedge clk_i) begin
    if (rst_i && exec_c && op_wr_c && !op_err_c) begin
      mem[op_idx_c] <= op_wdata_c;
    end
  end

  assign bus.busy_o = rst_i & busy_c;
  assign bus.done_o = (state_q == RESP);
  assign bus.data_o = rdata_q;
  assign bus.err_o  = err_q;

endmodule
